// File: rtl/gol_pkg.sv
// Shared constants and types for the Game of Life cell update path.
package gol_pkg;

  localparam int NEIGHBOURS_CNT = 8;

  localparam logic [2:0] NB_NW = 3'd0;
  localparam logic [2:0] NB_N  = 3'd1;
  localparam logic [2:0] NB_NE = 3'd2;
  localparam logic [2:0] NB_W  = 3'd3;
  localparam logic [2:0] NB_E  = 3'd4;
  localparam logic [2:0] NB_SW = 3'd5;
  localparam logic [2:0] NB_S  = 3'd6;
  localparam logic [2:0] NB_SE = 3'd7;

  localparam logic [3:0] BIRTH_CNT   = 4'd3;
  localparam logic [3:0] SURVIVE_CNT = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SELF  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/get_nbrs_address.sv
// Combinational neighbour address generator for a bounded field.
// North is y-1, west is x-1; neighbours outside the field are flagged irrelevant.
module get_nbrs_address
  import gol_pkg::*;
#(
  parameter int FIELD_W    = 4,
  parameter int FIELD_H    = 3,
  parameter int X_ADR_SIZE = $clog2(FIELD_W),
  parameter int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic [X_ADR_SIZE-1:0]                     i_x_adr,
  input  logic [Y_ADR_SIZE-1:0]                     i_y_adr,
  output logic [NEIGHBOURS_CNT-1:0][X_ADR_SIZE-1:0] o_nbrs_x_adr,
  output logic [NEIGHBOURS_CNT-1:0][Y_ADR_SIZE-1:0] o_nbrs_y_adr,
  output logic [NEIGHBOURS_CNT-1:0]                 o_nbrs_rlvnt
);

  localparam logic [X_ADR_SIZE-1:0] X_MAX = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_MAX = Y_ADR_SIZE'(FIELD_H - 1);

  logic                  has_w_s, has_e_s, has_n_s, has_s_s;
  logic [X_ADR_SIZE-1:0] xm_s, xp_s;
  logic [Y_ADR_SIZE-1:0] ym_s, yp_s;

  always_comb begin
    has_w_s = (i_x_adr != '0);
    has_e_s = (i_x_adr != X_MAX);
    has_n_s = (i_y_adr != '0);
    has_s_s = (i_y_adr != Y_MAX);
    xm_s    = i_x_adr - X_ADR_SIZE'(1);
    xp_s    = i_x_adr + X_ADR_SIZE'(1);
    ym_s    = i_y_adr - Y_ADR_SIZE'(1);
    yp_s    = i_y_adr + Y_ADR_SIZE'(1);

    o_nbrs_x_adr[NB_NW] = xm_s;    o_nbrs_y_adr[NB_NW] = ym_s;    o_nbrs_rlvnt[NB_NW] = has_n_s & has_w_s;
    o_nbrs_x_adr[NB_N]  = i_x_adr; o_nbrs_y_adr[NB_N]  = ym_s;    o_nbrs_rlvnt[NB_N]  = has_n_s;
    o_nbrs_x_adr[NB_NE] = xp_s;    o_nbrs_y_adr[NB_NE] = ym_s;    o_nbrs_rlvnt[NB_NE] = has_n_s & has_e_s;
    o_nbrs_x_adr[NB_W]  = xm_s;    o_nbrs_y_adr[NB_W]  = i_y_adr; o_nbrs_rlvnt[NB_W]  = has_w_s;
    o_nbrs_x_adr[NB_E]  = xp_s;    o_nbrs_y_adr[NB_E]  = i_y_adr; o_nbrs_rlvnt[NB_E]  = has_e_s;
    o_nbrs_x_adr[NB_SW] = xm_s;    o_nbrs_y_adr[NB_SW] = yp_s;    o_nbrs_rlvnt[NB_SW] = has_s_s & has_w_s;
    o_nbrs_x_adr[NB_S]  = i_x_adr; o_nbrs_y_adr[NB_S]  = yp_s;    o_nbrs_rlvnt[NB_S]  = has_s_s;
    o_nbrs_x_adr[NB_SE] = xp_s;    o_nbrs_y_adr[NB_SE] = yp_s;    o_nbrs_rlvnt[NB_SE] = has_s_s & has_e_s;
  end

endmodule

// File: rtl/cell_update_seq.sv
// Reads one cell and its 8 neighbours from the field RAM and applies B3/S23.
// GOL_TORUS_WRAP_EN selects a toroidal field (all neighbours read, coordinates wrap).
module cell_update_seq
  import gol_pkg::*;
#(
  parameter int FIELD_W    = 4,
  parameter int FIELD_H    = 3,
  parameter int X_ADR_SIZE = $clog2(FIELD_W),
  parameter int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [X_ADR_SIZE-1:0] i_cell_x_adr,
  input  logic [Y_ADR_SIZE-1:0] i_cell_y_adr,
  output logic                  o_rd_en,
  output logic [X_ADR_SIZE-1:0] o_rd_x_adr,
  output logic [Y_ADR_SIZE-1:0] o_rd_y_adr,
  input  logic                  i_rd_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [3:0]            o_live_cnt,
  output logic                  o_next_state
);

  seq_state_t            state_q;
  logic [X_ADR_SIZE-1:0] cell_x_q, rd_x_q;
  logic [Y_ADR_SIZE-1:0] cell_y_q, rd_y_q;
  logic [2:0]            idx_q;
  logic                  rd_en_q, tag_q, vld_q, vld_tag_q, self_q;
  logic [3:0]            cnt_q, cnt_d, live_cnt_q;
  logic                  done_q, next_state_q, next_state_d;

  logic [2:0]            nxt_idx_s;
  logic                  nb_en_s;
  logic [X_ADR_SIZE-1:0] nb_x_s;
  logic [Y_ADR_SIZE-1:0] nb_y_s;

  logic [NEIGHBOURS_CNT-1:0][X_ADR_SIZE-1:0] nbrs_x_s;
  logic [NEIGHBOURS_CNT-1:0][Y_ADR_SIZE-1:0] nbrs_y_s;
  logic [NEIGHBOURS_CNT-1:0]                 nbrs_rlvnt_s;

  get_nbrs_address #(
    .FIELD_W   (FIELD_W),
    .FIELD_H   (FIELD_H),
    .X_ADR_SIZE(X_ADR_SIZE),
    .Y_ADR_SIZE(Y_ADR_SIZE)
  ) u_nbrs (
    .i_x_adr     (cell_x_q),
    .i_y_adr     (cell_y_q),
    .o_nbrs_x_adr(nbrs_x_s),
    .o_nbrs_y_adr(nbrs_y_s),
    .o_nbrs_rlvnt(nbrs_rlvnt_s)
  );

`ifdef GOL_TORUS_WRAP_EN
  localparam logic [X_ADR_SIZE-1:0] X_MAX = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_MAX = Y_ADR_SIZE'(FIELD_H - 1);
  logic [X_ADR_SIZE-1:0] xm_s, xp_s;
  logic [Y_ADR_SIZE-1:0] ym_s, yp_s;
`endif

  // Address and enable of the read issued in the next cycle.
  always_comb begin
    if (state_q == ST_SCAN) begin
      nxt_idx_s = idx_q + 3'd1;
    end else begin
      nxt_idx_s = 3'd0;
    end
`ifdef GOL_TORUS_WRAP_EN
    xm_s    = (cell_x_q == '0)    ? X_MAX : cell_x_q - X_ADR_SIZE'(1);
    xp_s    = (cell_x_q == X_MAX) ? '0    : cell_x_q + X_ADR_SIZE'(1);
    ym_s    = (cell_y_q == '0)    ? Y_MAX : cell_y_q - Y_ADR_SIZE'(1);
    yp_s    = (cell_y_q == Y_MAX) ? '0    : cell_y_q + Y_ADR_SIZE'(1);
    nb_en_s = 1'b1;
    case (nxt_idx_s)
      NB_NW, NB_W, NB_SW: nb_x_s = xm_s;
      NB_NE, NB_E, NB_SE: nb_x_s = xp_s;
      default:            nb_x_s = cell_x_q;
    endcase
    case (nxt_idx_s)
      NB_NW, NB_N, NB_NE: nb_y_s = ym_s;
      NB_SW, NB_S, NB_SE: nb_y_s = yp_s;
      default:            nb_y_s = cell_y_q;
    endcase
`else
    nb_en_s = nbrs_rlvnt_s[nxt_idx_s];
    nb_x_s  = nbrs_x_s[nxt_idx_s];
    nb_y_s  = nbrs_y_s[nxt_idx_s];
`endif
  end

  // Count including the datum returning this cycle, and the rule applied to it.
  always_comb begin
    cnt_d        = cnt_q + {3'b000, vld_q & vld_tag_q & i_rd_data};
    next_state_d = (cnt_d == BIRTH_CNT) | (self_q & (cnt_d == SURVIVE_CNT));
  end

  // Sequencer, read pipeline and result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      cell_x_q     <= '0;
      cell_y_q     <= '0;
      idx_q        <= 3'd0;
      rd_en_q      <= 1'b0;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
      tag_q        <= 1'b0;
      vld_q        <= 1'b0;
      vld_tag_q    <= 1'b0;
      self_q       <= 1'b0;
      cnt_q        <= 4'd0;
      done_q       <= 1'b0;
      live_cnt_q   <= 4'd0;
      next_state_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      vld_q     <= rd_en_q;
      vld_tag_q <= tag_q;
      cnt_q     <= cnt_d;
      if (vld_q && !vld_tag_q) begin
        self_q <= i_rd_data;
      end
      case (state_q)
        ST_IDLE: begin
          rd_en_q <= 1'b0;
          rd_x_q  <= '0;
          rd_y_q  <= '0;
          tag_q   <= 1'b0;
          if (i_start) begin
            state_q  <= ST_SELF;
            cell_x_q <= i_cell_x_adr;
            cell_y_q <= i_cell_y_adr;
            cnt_q    <= 4'd0;
            rd_en_q  <= 1'b1;
            rd_x_q   <= i_cell_x_adr;
            rd_y_q   <= i_cell_y_adr;
          end
        end
        ST_SELF, ST_SCAN: begin
          if (state_q == ST_SCAN && idx_q == 3'd7) begin
            state_q <= ST_DRAIN;
            rd_en_q <= 1'b0;
            rd_x_q  <= '0;
            rd_y_q  <= '0;
            tag_q   <= 1'b0;
          end else begin
            state_q <= ST_SCAN;
            idx_q   <= nxt_idx_s;
            rd_en_q <= nb_en_s;
            rd_x_q  <= nb_en_s ? nb_x_s : '0;
            rd_y_q  <= nb_en_s ? nb_y_s : '0;
            tag_q   <= 1'b1;
          end
        end
        ST_DRAIN: begin
          state_q      <= ST_DONE;
          done_q       <= 1'b1;
          live_cnt_q   <= cnt_d;
          next_state_q <= next_state_d;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rd_en      = rd_en_q;
  assign o_rd_x_adr   = rd_x_q;
  assign o_rd_y_adr   = rd_y_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = done_q;
  assign o_live_cnt   = live_cnt_q;
  assign o_next_state = next_state_q;

endmodule

// File: tb/tb_cell_update_seq.sv
// Scoreboard bench for cell_update_seq: a 4x3 field RAM with 1-cycle read latency,
// a neighbour-sum reference model, and a monitor checking read slots and results.
module tb_cell_update_seq;

  localparam int W = 4;
  localparam int H = 3;
  localparam int DX [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  localparam int DY [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
`ifdef GOL_TORUS_WRAP_EN
  localparam int C00 = 8; localparam int N00 = 0; localparam int C31 = 8;
`else
  localparam int C00 = 3; localparam int N00 = 1; localparam int C31 = 5;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cx = 2'd0;
  logic [1:0] cy = 2'd0;
  logic       rd_en, busy, done, nxt;
  logic [1:0] rd_x, rd_y;
  logic       rd_data = 1'b0;
  logic [3:0] live_cnt;

  bit mem [H][W];
  int rd_q[$];
  int res_q[$];
  int checks = 0;
  int errs = 0;
  int busy_cyc = 0;

  cell_update_seq #(.FIELD_W(W), .FIELD_H(H)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_cell_x_adr(cx), .i_cell_y_adr(cy),
    .o_rd_en(rd_en), .o_rd_x_adr(rd_x), .o_rd_y_adr(rd_y),
    .i_rd_data(rd_data), .o_busy(busy), .o_done(done),
    .o_live_cnt(live_cnt), .o_next_state(nxt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_y][rd_x];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pack_rd(input int en, input int x, input int y);
    return (en << 4) | (x << 2) | y;
  endfunction

  // Reference: queue the 9 expected read slots, return {count, next_state}.
  function automatic int model(input int x, input int y);
    int cnt = 0;
    int self_v = int'(mem[y][x]);
    rd_q.push_back(pack_rd(1, x, y));
    for (int k = 0; k < 8; k++) begin
      int nx = x + DX[k];
      int ny = y + DY[k];
      bit en;
`ifdef GOL_TORUS_WRAP_EN
      nx = (nx + W) % W;
      ny = (ny + H) % H;
      en = 1'b1;
`else
      en = (nx >= 0) && (nx < W) && (ny >= 0) && (ny < H);
`endif
      if (en) begin
        rd_q.push_back(pack_rd(1, nx, ny));
        cnt += int'(mem[ny][nx]);
      end else begin
        rd_q.push_back(0);
      end
    end
    return (cnt << 1) | ((cnt == 3 || (self_v == 1 && cnt == 2)) ? 1 : 0);
  endfunction

  task automatic fill(input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (mode)
          0:       mem[y][x] = 1'b1;
          1:       mem[y][x] = (y == 1 && x < 3);
          default: mem[y][x] = bit'($urandom_range(0, 1));
        endcase
  endtask

  task automatic run_cell(input int x, input int y, input int glitch,
                          input bit use_const, input int ccnt, input int cnext);
    int r;
    bit idle_seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    cx = 2'(x);
    cy = 2'(y);
    r = model(x, y);
    res_q.push_back(use_const ? ((ccnt << 1) | cnext) : r);
    @(posedge clk);
    #1;
    start = 1'b0;
    cx = 2'($urandom_range(0, 3));
    cy = 2'($urandom_range(0, 2));
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == glitch) begin
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
    end
    if (!idle_seen) check("busy_timeout", 1, 0);
  endtask

  // Monitor: read slots in the first 9 busy cycles, result when o_done shows.
  always @(negedge clk) begin
    int exp;
    if (rst) begin
      busy_cyc = 0;
    end else if (busy) begin
      if (busy_cyc < 9) begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          exp = rd_q.pop_front();
          check("rd_slot", int'({rd_en, rd_x, rd_y}), exp);
        end
      end else begin
        check("rd_quiet", int'(rd_en), 0);
      end
      if (done) begin
        check("done_latency", busy_cyc, 10);
        if (res_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          exp = res_q.pop_front();
          check("live_cnt", int'(live_cnt), exp >> 1);
          check("next_state", int'(nxt), exp & 1);
        end
      end
      busy_cyc++;
    end else begin
      if (done) check("done_while_idle", 1, 0);
      busy_cyc = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_rd", int'({rd_en, rd_x, rd_y}), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'({live_cnt, nxt}), 0);
    rst = 1'b0;

    fill(0);
    run_cell(0, 0, 0, 1'b1, C00, N00);
    run_cell(1, 1, 0, 1'b1, 8, 0);
    run_cell(3, 1, 0, 1'b1, C31, 0);
    run_cell(0, 0, 3, 1'b1, C00, N00);
    fill(1);
    run_cell(1, 0, 0, 1'b1, 3, 1);
    run_cell(0, 1, 0, 1'b1, 1, 0);

    // Abort mid-scan with reset, then a normal evaluation afterwards.
    fill(0);
    @(negedge clk);
    start = 1'b1;
    cx = 2'd1;
    cy = 2'd1;
    void'(model(1, 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_rd_en", int'(rd_en), 0);
    check("abort_live_cnt", int'(live_cnt), 0);
    check("abort_done", int'(done), 0);
    rd_q.delete();
    res_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    run_cell(1, 1, 0, 1'b1, 8, 0);

    for (int n = 0; n < 30; n++) begin
      int g = $urandom_range(0, 3);
      fill(2);
      run_cell($urandom_range(0, W - 1), $urandom_range(0, H - 1),
               (g == 0) ? 0 : $urandom_range(2, 9), 1'b0, 0, 0);
    end

    repeat (5) @(negedge clk);
    check("results_drained", res_q.size(), 0);
    check("reads_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cell_update_seq.md
# cell_update_seq

Sequencer that computes the next Game of Life state of one cell. It drives the combinational neighbour-address generator `get_nbrs_address`, issues one field-memory read per cycle (own cell, then neighbours 0..7), and counts live neighbours. It then applies the B3/S23 rule. It sits between the field-update controller (which walks cells) and the synchronous field RAM read port.

## Interface
- `FIELD_W`, default 4: field width in cells.
- `FIELD_H`, default 3: field height in cells.
- `X_ADR_SIZE`, default `$clog2(FIELD_W)`: x address width (derived, not overridden).
- `Y_ADR_SIZE`, default `$clog2(FIELD_H)`: y address width (derived, not overridden).

Ports:
- `i_clk`  in  1  clock; one clock domain.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_start`  in  1  request to evaluate the cell; sampled only in IDLE.
- `i_cell_x_adr`  in  X_ADR_SIZE  cell x; latched when start is accepted.
- `i_cell_y_adr`  in  Y_ADR_SIZE  cell y; latched when start is accepted.
- `o_rd_en`  out  1  field RAM read strobe.
- `o_rd_x_adr`  out  X_ADR_SIZE  RAM read x address.
- `o_rd_y_adr`  out  Y_ADR_SIZE  RAM read y address.
- `i_rd_data`  in  1  RAM data; valid exactly 1 cycle after `o_rd_en`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse; result is valid.
- `o_live_cnt`  out  4  live neighbour count, 0..8.
- `o_next_state`  out  1  next cell state.

## Operation
- FSM states: IDLE → SELF → SCAN → DRAIN → DONE → IDLE.
- IDLE: when `i_start`=1, latch the cell address, clear the internal count, go to SELF.
- SELF: `o_rd_en`=1 at the latched cell address, go to SCAN with idx=0.
- SCAN: 3-bit idx steps 0..7, one per cycle; leave SCAN after idx=7.
  - Neighbour order matches `get_nbrs_address`: 0=NW, 1=N, 2=NE, 3=W, 4=E, 5=SW, 6=S, 7=SE.
  - If `o_nbrs_rlvnt[idx]`=1: `o_rd_en`=1 with that neighbour's address.
  - If `o_nbrs_rlvnt[idx]`=0: `o_rd_en`=0, and the neighbour counts as dead. Only the enable changes; the schedule does not shrink.
- Pipeline: a 1-bit tag registered with `o_rd_en` marks returning data as self or neighbour.
  - Neighbour data adds 1 to the count when 1.
  - Self data is stored as the current state.
- DRAIN: collects the last returning datum. No read is issued.
- DONE:
  - `o_done`=1.
  - `o_live_cnt` = final count.
  - `o_next_state` = (cnt==3) | (self & cnt==2).
  - Go to IDLE.
- Result outputs hold until the next DONE.
- `i_start` while busy is ignored; it is neither queued nor restarted.
- Address inputs are don't-care after latching.
- Count arithmetic: 4-bit unsigned. The maximum is 8, so there is no overflow.
- `o_rd_x_adr`/`o_rd_y_adr` are 0 whenever `o_rd_en`=0.

## Timing
- Fixed latency. Start is accepted at edge T. Then:
  - SELF occupies cycle T+1.
  - SCAN occupies cycles T+2..T+9.
  - DRAIN occupies cycle T+10.
  - `o_done` is high in cycle T+11.
- The earliest next start is sampled in cycle T+12 (IDLE). Back-to-back throughput is 1 cell per 12 cycles.
- All outputs are registered or decoded from registered state; there is no combinational path from `i_start` to any output.
- Reset values: state=IDLE, `o_rd_en`=0, rd addresses=0, `o_busy`=0, `o_done`=0, `o_live_cnt`=0, `o_next_state`=0, pipeline tag=0.
- Reset mid-operation: outputs go to reset values immediately (asynchronously). Data returning from the aborted read is discarded. No `o_done` follows.

## Configuration
- `GOL_TORUS_WRAP_EN` defined: toroidal field.
  - All 8 neighbours are read every cell.
  - Out-of-field coordinates wrap: x=-1→FIELD_W-1, x=FIELD_W→0; y likewise.
  - `o_nbrs_rlvnt` is ignored.
- `GOL_TORUS_WRAP_EN` undefined: bounded field. Irrelevant neighbours are skipped and count as dead, as described in Operation.
- Latency is identical in both modes.

## Structure
- `gol_pkg` holds:
  - `NEIGHBOURS_CNT`=8.
  - The neighbour index localparams (`NB_NW`..`NB_SE`).
  - The FSM state enum `seq_state_t`.
  - `BIRTH_CNT`=3 and `SURVIVE_CNT`=2.
- Sub-module: one instance of the existing `get_nbrs_address`, fed from the latched cell address.
- The wrap-address logic is local to this block and lives under the macro.

## Test plan
Bench models a 1-cycle-latency RAM holding a 4x3 field.
- All cells 1, bounded mode, start (0,0) → reads at T+1 (0,0), then (1,0), (0,1), (1,1); `o_done` at T+11, `o_live_cnt`=3, `o_next_state`=1.
- All cells 1, bounded mode, start (1,1) → 9 reads, `o_live_cnt`=8, `o_next_state`=0. Start (3,1) → `o_live_cnt`=5, `o_next_state`=0.
- Blinker: cells (0,1), (1,1), (2,1) set, start (1,0) → `o_live_cnt`=3, `o_next_state`=1. Start (0,1) → `o_live_cnt`=1, `o_next_state`=0.
- `GOL_TORUS_WRAP_EN`, all cells 1, start (0,0) → `o_rd_en` in all 9 cycles; NW read at (3,2); `o_live_cnt`=8, `o_next_state`=0.
- `i_start` pulsed at T+4 during SCAN → ignored; single `o_done` at T+11; the result is for the original cell.
- `i_rst` asserted at T+5 → `o_busy`, `o_rd_en`, `o_live_cnt` are 0 immediately; no `o_done`. A new start after reset release completes normally in 11 cycles.
